// File: rtl/cache_line_ctrl.sv
// Direct-mapped write-through read-allocate cache controller.
// Owns tag/valid store, refills 4-word lines, forwards all stores.
module cache_line_ctrl #(
  parameter int TAG_W = 23,
  parameter int IDX_W = 5,
  parameter int OFF_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [IDX_W+OFF_W-1:0] arr_addr,
  output logic [31:0] arr_wdata,
  output logic        arr_write,
  output logic [3:0]  arr_byte_w_en,
  input  logic [31:0] arr_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int AW    = IDX_W + OFF_W;
  localparam int WA    = TAG_W + AW;

  typedef enum logic [1:0] {
    IDLE, REFILL, WMEM, DONE
  } state_t;

  state_t            state;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINES-1:0]  valid;
  logic [OFF_W-1:0]  cnt;
  logic [WA-1:0]     lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;
  logic              lat_hit;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [AW-1:0]     a_word;
  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_idx;
  logic              hit;
  logic              unused_lsb;

  assign a_tag   = cpu_addr[31 -: TAG_W];
  assign a_idx   = cpu_addr[2+OFF_W +: IDX_W];
  assign a_word  = cpu_addr[2 +: AW];
  assign lat_tag = lat_addr[WA-1 -: TAG_W];
  assign lat_idx = lat_addr[OFF_W +: IDX_W];
  assign hit     = cpu_req & valid[a_idx]
                 & (tags[a_idx] == a_tag);
  assign unused_lsb = ^cpu_addr[1:0];
  assign cpu_rdata  = arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_hit   <= 1'b0;
      for (int i = 0; i < LINES; i++)
        tags[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            lat_addr  <= cpu_addr[31:2];
            lat_wdata <= cpu_wdata;
            lat_be    <= cpu_byte_en;
            lat_hit   <= hit;
            state     <= WMEM;
          end else if (cpu_req && !hit) begin
            lat_addr     <= cpu_addr[31:2];
            valid[a_idx] <= 1'b0;
            cnt          <= '0;
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              tags[lat_idx]  <= lat_tag;
              valid[lat_idx] <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        WMEM: if (mem_ack) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall     = 1'b0;
    arr_addr      = a_word;
    arr_wdata     = '0;
    arr_write     = 1'b0;
    arr_byte_w_en = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_byte_en   = '0;
    unique case (state)
      IDLE: cpu_stall = rst & cpu_req & (cpu_we | ~hit);
      REFILL: begin
        cpu_stall   = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {lat_addr[WA-1:OFF_W], cnt, 2'b00};
        mem_byte_en = 4'hF;
        arr_addr    = {lat_idx, cnt};
        if (mem_ack) begin
          arr_write     = 1'b1;
          arr_wdata     = mem_rdata;
          arr_byte_w_en = 4'hF;
        end
      end
      WMEM: begin
        cpu_stall   = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {lat_addr, 2'b00};
        mem_wdata   = lat_wdata;
        mem_byte_en = lat_be;
      end
      DONE: begin
        // store miss does not allocate
        if (lat_hit) begin
          arr_write     = 1'b1;
          arr_addr      = lat_addr[AW-1:0];
          arr_wdata     = lat_wdata;
          arr_byte_w_en = lat_be;
        end
      end
      default: cpu_stall = 1'b0;
    endcase
  end

endmodule

// File: doc/cache_line_ctrl.md
# cache_line_ctrl

Direct-mapped, write-through, read-allocate cache controller that drives the word-wide cache data array with byte write enables, 7-bit word address and combinational read. It sits between the CPU memory stage and that array: it holds the tag/valid store, detects hits, stalls the CPU on misses, refills 4-word lines from main memory word by word, and forwards every store to memory.

## Interface
- `TAG_W`, default 23: tag width, equal to 32 − `IDX_W` − `OFF_W` − 2.
- `IDX_W`, default 5: set index width (32 lines).
- `OFF_W`, default 2: word-in-line offset width (4 words/line). `IDX_W`+`OFF_W` = 7 = array address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: store data.
- `cpu_byte_en` in 4: store byte lanes.
- `cpu_rdata` out 32: load data, always equal to `arr_rdata`.
- `cpu_stall` out 1: CPU must hold all `cpu_*` inputs while high.
- `arr_addr` out 7: data array word address.
- `arr_wdata` out 32: data array write data.
- `arr_write` out 1: data array write strobe.
- `arr_byte_w_en` out 4: data array byte enables.
- `arr_rdata` in 32: data array read data (combinational from `arr_addr`).
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: memory word address, bits [1:0] = 0.
- `mem_wdata` out 32: memory write data.
- `mem_byte_en` out 4: memory byte lanes.
- `mem_ack` in 1: one-cycle completion for the current word.
- `mem_rdata` in 32: read data, valid when `mem_ack` is high.

## Operation
- Address split: tag = [31:9], idx = [8:4], off = [3:2]. Tag store holds 32 × (tag, valid), kept in registers.
- hit = `cpu_req` & valid[idx] & (tag[idx] == addr tag).
- FSM states: IDLE, REFILL, WMEM, DONE.
- IDLE, `arr_addr` = `cpu_addr`[8:2]:
  - no request, or load hit: `cpu_stall`=0.
  - load miss: `cpu_stall`=1; latch address; clear valid[idx]; cnt=0; go to REFILL.
  - store: `cpu_stall`=1; latch addr/data/byte_en and the hit flag; go to WMEM.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={latched tag, idx, cnt, 2'b00}, `mem_byte_en`=4'hF.
  - On `mem_ack`: `arr_write`=1, `arr_addr`={idx, cnt}, `arr_wdata`=`mem_rdata`, `arr_byte_w_en`=4'hF; cnt increments.
  - On `mem_ack` with cnt==3: write tag, set valid, go to IDLE. The still-held load then hits.
- WMEM:
  - `mem_req`=1, `mem_we`=1, latched addr/data/byte_en.
  - On `mem_ack`: go to DONE.
- DONE:
  - `cpu_stall`=0 for exactly one cycle; the store retires.
  - If the latched hit flag is set: `arr_write`=1 with latched address, data and byte_en. A store miss does not allocate.
  - Go to IDLE.
- `cpu_stall` is high in REFILL and WMEM.
- `arr_write` is 0 except as stated above.
- `mem_*` outputs are 0 whenever `mem_req` is 0.
- cnt wraps from 3 to 0 and is unused outside REFILL.

## Timing
- Reset (rst=0), taking effect immediately:
  - state=IDLE; all valid bits 0; cnt=0.
  - `mem_req`=0, `arr_write`=0, `cpu_stall`=0.
  - `mem_addr`/`mem_wdata`/`mem_byte_en`/`arr_wdata`/`arr_byte_w_en`=0.
- Reset during REFILL or WMEM abandons the transaction. `mem_req` drops asynchronously. The partially refilled line stays invalid.
- Load hit: zero added cycles; data appears combinationally in the request cycle.
- Load miss: 1 detect cycle, then 4 memory words, then 1 hit cycle in IDLE. Minimum 6 cycles with `mem_ack` in every REFILL cycle.
- Store: IDLE, then WMEM (≥1 cycle), then DONE. Minimum 3 cycles; `cpu_stall` is low only in the DONE cycle.
- Memory handshake:
  - `mem_req` stays high and `mem_addr` stays stable until `mem_ack`.
  - `mem_ack` is legal in any cycle with `mem_req`=1, including the first.
  - Refill requests are back-to-back. `mem_addr` advances in the cycle after each ack.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- Reset, then load 0x0000_0100 with memory returning 0xA0..0xA3 → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; array writes at addresses 0x40–0x43; `cpu_rdata`=0xA0 when stall falls.
- Load 0x0000_0108 after that refill → hit, `cpu_stall`=0 in the request cycle, `cpu_rdata`=0xA2, `mem_req` stays 0.
- Store 0x0000AB00 to 0x104 with byte_en 4'b0010, ack delayed 3 cycles → memory write with byte_en 4'b0010; array write at 0x41 only in DONE; stall high 4 cycles; later load 0x104 returns word 0xA1 with byte 1 replaced by 0xAB.
- Store to 0x0000_0200 (invalid line) → memory write only, no array write; next load 0x200 misses and refills.
- Conflict: load 0x100, then load 0x300 → same idx 0x10, second load refills and evicts; load 0x100 misses again.
- Assert rst after 2 refill acks → `mem_req`=0 immediately; after release, load to the same address misses and performs a full 4-word refill.
